// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared occupancy-state type and statistics width for fifo_drain
package fifo_drain_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} drain_state_t;
  localparam int STATS_W = 32;
endpackage

// File: rtl/burst_beat_cnt.sv
// burst_beat_cnt: beat position within a burst, 0..BURST-1, wrapping on inc
// Ports: clk, reset (sync, active-high), clr (sync clear), inc (advance), cnt (position), at_last (cnt==BURST-1)
module burst_beat_cnt #(
  parameter int BURST = 4,
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_last
);
  assign at_last = cnt == CW'(BURST - 1);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc) cnt <= at_last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops a sync FIFO into a 2-entry skid buffer and presents words as a valid/ready stream in BURST-beat bursts
// Ports: clk, reset (sync, active-high); fifo_empty_i/fifo_data_i/fifo_pop_o to the FIFO head;
// flush_i discards buffered words and burst position; out_valid_o/out_data_o/out_last_o/out_ready_i stream.
// Macro FIFO_DRAIN_STATS_EN adds words_sent_o, a wrapping count of accepted beats.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BURST  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_empty_i,
  input  logic [DATA_W-1:0]  fifo_data_i,
  output logic               fifo_pop_o,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_last_o,
`ifdef FIFO_DRAIN_STATS_EN
  output logic [STATS_W-1:0] words_sent_o,
`endif
  input  logic               out_ready_i
);
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  drain_state_t state, state_n;
  logic [DATA_W-1:0] skid;
  logic [CW-1:0] cnt;
  logic pop, fire, at_last, load_out, load_skid;
  // Pop never looks at out_ready_i so the FIFO is isolated from downstream backpressure.
  assign pop = !fifo_empty_i && !flush_i && state != TWO && !reset;
  assign fifo_pop_o = pop;
  assign out_valid_o = state != EMPTY;
  assign fire = out_valid_o && out_ready_i;
  assign out_last_o = out_valid_o && at_last;
  assign load_out = !flush_i && ((state == EMPTY && pop) || (state == ONE && pop && fire) || (state == TWO && fire));
  assign load_skid = !flush_i && state == ONE && pop && !fire;
  always_comb
    state_n = flush_i ? EMPTY :
              state == EMPTY ? (pop ? ONE : EMPTY) :
              state == ONE ? (pop && !fire ? TWO : !pop && fire ? EMPTY : ONE) :
              (fire ? ONE : TWO);
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      out_data_o <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      if (load_out) out_data_o <= state == TWO ? skid : fifo_data_i;
      if (load_skid) skid <= fifo_data_i;
    end
  burst_beat_cnt #(.BURST(BURST)) u_beat (
    .clk(clk), .reset(reset), .clr(flush_i), .inc(fire), .cnt(cnt), .at_last(at_last)
  );
  a_last_decode: assert property (@(posedge clk) at_last == (cnt == CW'(BURST - 1)));
`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk)
    if (reset) words_sent_o <= '0;
    else if (fire) words_sent_o <= words_sent_o + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed scenarios against a queue-level model of the FIFO and the drain buffer
module tb_fifo_drain;
  localparam int BURST = 4;
  logic clk = 0, reset = 1, fifo_empty_i = 1, flush_i = 0, out_ready_i = 0;
  logic [15:0] fifo_data_i = '0;
  logic fifo_pop_o, out_valid_o, out_last_o;
  logic [15:0] out_data_o;
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] words_sent_o;
`endif
  fifo_drain #(.DATA_W(16), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_pop_o(fifo_pop_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
`ifdef FIFO_DRAIN_STATS_EN
    .words_sent_o(words_sent_o),
`endif
    .out_ready_i(out_ready_i)
  );
  always #5 clk = ~clk;
  logic [15:0] fifo_q[$], buf_q[$], got_d[$], exp_d[$];
  bit got_l[$];
  int beat = 0, sent = 0, errs = 0, checks = 0;
  bit chk_en = 0, d_pop = 0, d_fire = 0, ev;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive_fifo();
    fifo_empty_i = fifo_q.size() == 0;
    fifo_data_i = fifo_q.size() == 0 ? 16'h0 : fifo_q[0];
  endtask
  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask
  always @(negedge clk)
    if (chk_en) begin
      ev = buf_q.size() != 0;
      chk("out_valid", out_valid_o, ev);
      if (ev) chk("out_data", out_data_o, buf_q[0]);
      chk("out_last", out_last_o, ev && beat == BURST - 1);
      d_pop = fifo_q.size() != 0 && !flush_i && buf_q.size() < 2 && !reset;
      chk("fifo_pop", fifo_pop_o, d_pop);
      d_fire = ev && out_ready_i;
`ifdef FIFO_DRAIN_STATS_EN
      chk("words_sent", words_sent_o, sent);
`endif
      if (d_fire && !reset) begin
        got_d.push_back(buf_q[0]);
        got_l.push_back(beat == BURST - 1);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      buf_q.delete();
      beat = 0;
      sent = 0;
    end else if (flush_i) begin
      if (d_fire) sent++;
      buf_q.delete();
      beat = 0;
    end else begin
      if (d_fire) begin
        void'(buf_q.pop_front());
        beat = (beat + 1) % BURST;
        sent++;
      end
      if (d_pop) buf_q.push_back(fifo_q[0]);
    end
    if (d_pop) void'(fifo_q.pop_front());
    drive_fifo();
  endtask
  task automatic check_got(input string n, input int len, input logic [15:0] base, input int last_idx0, input int last_idx1);
    chk({n, "_count"}, got_d.size(), len);
    for (int i = 0; i < len; i++) begin
      chk({n, "_word"}, i < got_d.size() ? got_d[i] : 16'hxxxx, base + 16'(i));
      chk({n, "_lastflag"}, i < got_l.size() ? got_l[i] : 1'bx, i == last_idx0 || i == last_idx1);
    end
  endtask
  initial begin
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_pop", fifo_pop_o, 0);
    // 1: eight words streamed at full rate, last on 4th and 8th beat
    out_ready_i = 1;
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    got_d.delete(); got_l.delete();
    repeat (9) tick();
    chk("s1_valid_after_9", out_valid_o, 0);
    check_got("s1", 8, 16'h1000, 3, 7);
`ifdef FIFO_DRAIN_STATS_EN
    chk("s1_words_sent", words_sent_o, 8);
`endif
    // 2: backpressure lets exactly two words out of the FIFO
    out_ready_i = 0;
    for (int i = 0; i < 3; i++) push(16'hA000 + 16'(i));
    tick();
    tick();
    chk("s2_fifo_left", fifo_q.size(), 1);
    chk("s2_pop_held", fifo_pop_o, 0);
    chk("s2_head", out_data_o, 16'hA000);
    tick();
    chk("s2_pop_still_held", fifo_pop_o, 0);
    out_ready_i = 1;
    got_d.delete(); got_l.delete();
    repeat (4) tick();
    check_got("s2", 3, 16'hA000, -1, -1);
    // 3: random words with downstream ready toggling every cycle
    got_d.delete(); got_l.delete(); exp_d.delete();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      exp_d.push_back(w);
      push(w);
    end
    for (int i = 0; i < 30; i++) begin
      out_ready_i = ~out_ready_i;
      tick();
    end
    out_ready_i = 1;
    repeat (3) tick();
    chk("s3_count", got_d.size(), 8);
    for (int i = 0; i < 8; i++) chk("s3_word", i < got_d.size() ? got_d[i] : 16'hxxxx, exp_d[i]);
    // 4: flush while two words are buffered after one beat of a fresh burst
    flush_i = 1;
    tick();
    flush_i = 0;
    push(16'hAFFF);
    tick();
    push(16'hB000); push(16'hB001);
    tick();
    out_ready_i = 0;
    tick();
    chk("s4_head", out_data_o, 16'hB000);
    chk("s4_fifo_drained", fifo_q.size(), 0);
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("s4_flushed_valid", out_valid_o, 0);
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
    out_ready_i = 1;
    got_d.delete(); got_l.delete();
    repeat (6) tick();
    check_got("s4", 4, 16'hC000, 3, -1);
    // 5: reset two beats into a burst; next burst ends on its 4th beat
    for (int i = 0; i < 7; i++) push(16'hD000 + 16'(i));
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("s5_valid", out_valid_o, 0);
    chk("s5_data", out_data_o, 0);
    chk("s5_last", out_last_o, 0);
    got_d.delete(); got_l.delete();
    repeat (6) tick();
    check_got("s5", 4, 16'hD003, 3, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
